// File: rtl/bt_pipe_out_buffer.sv
// Circular word buffer feeding a block-throttled output pipe endpoint.
// Optional flush padding enabled by defining BT_PIPE_OUT_BUF_PAD_EN.
module bt_pipe_out_buffer #(
    parameter int          ADDR_W      = 6,
    parameter int          BLOCK_WORDS = 16,
    parameter logic [31:0] PAD_WORD    = 32'h0
) (
    input  logic              okClk,
    input  logic              rst_n,
    input  logic [31:0]       in_data,
    input  logic              in_valid,
    output logic              in_ready,
`ifdef BT_PIPE_OUT_BUF_PAD_EN
    input  logic              flush,
`endif
    output logic [31:0]       ep_datain,
    output logic              ep_ready,
    input  logic              ep_read,
    input  logic              ep_blockstrobe,
    output logic [ADDR_W:0]   level,
    output logic              underflow,
    output logic              frame_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] BW_L    = (ADDR_W + 1)'(BLOCK_WORDS);

`ifdef BT_PIPE_OUT_BUF_PAD_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLOCK = 2'd1,
        PAD   = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        BLOCK = 1'b1
    } state_t;
`endif

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nx;
    logic [ADDR_W:0]   level_next;
    logic [31:0]       wr_word;
    logic              wr;
    logic              rd;
    logic              ferr_set;
    logic              in_ready_nx;
    state_t            state;
    state_t            state_nx;
    state_t            frame_st;
    state_t            frame_nx;

`ifdef BT_PIPE_OUT_BUF_PAD_EN
    state_t            ret_state;
    logic              pad_wr;
    logic              flush_go;
    logic              pad_done;
`endif

    // Write/read qualification and the post-edge word count.
    always_comb begin
`ifdef BT_PIPE_OUT_BUF_PAD_EN
        pad_wr   = (state == PAD) && ((level % BW_L) != '0)
                   && (level < DEPTH_L);
        wr       = (in_valid & in_ready) | pad_wr;
        wr_word  = pad_wr ? PAD_WORD : in_data;
        frame_st = (state == PAD) ? ret_state : state;
`else
        wr       = in_valid & in_ready;
        wr_word  = in_data;
        frame_st = state;
`endif
        rd         = ep_read && (level != '0);
        level_next = level + {{ADDR_W{1'b0}}, wr}
                           - {{ADDR_W{1'b0}}, rd};
    end

    // Block framing: counts reads within a strobed block, flags misuse.
    always_comb begin
        frame_nx = frame_st;
        cnt_nx   = cnt;
        ferr_set = 1'b0;
        if (frame_st == BLOCK) begin
            if (ep_blockstrobe) begin
                ferr_set = 1'b1;
                cnt_nx   = '0;
            end else if (ep_read) begin
                if (cnt + 1'b1 == BW_L) begin
                    frame_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
        end else begin
            if (ep_blockstrobe) begin
                frame_nx = BLOCK;
                cnt_nx   = '0;
            end else if (ep_read) begin
                ferr_set = 1'b1;
            end
        end
    end

    // Next FSM state, with padding layered over the framing state.
    always_comb begin
`ifdef BT_PIPE_OUT_BUF_PAD_EN
        flush_go = flush && (state != PAD) && ((level % BW_L) != '0);
        pad_done = ((level_next % BW_L) == '0)
                   || (level_next == DEPTH_L);
        if (state == PAD) begin
            state_nx = pad_done ? frame_nx : PAD;
        end else if (flush_go) begin
            state_nx = PAD;
        end else begin
            state_nx = frame_nx;
        end
        in_ready_nx = (level_next < DEPTH_L) && (state_nx != PAD);
`else
        state_nx    = frame_nx;
        in_ready_nx = level_next < DEPTH_L;
`endif
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge okClk) begin
        if (wr) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // Pointers, level, registered outputs, sticky flags and FSM.
    always_ff @(posedge okClk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            in_ready  <= 1'b0;
            ep_datain <= '0;
            ep_ready  <= 1'b0;
            underflow <= 1'b0;
            frame_err <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
`ifdef BT_PIPE_OUT_BUF_PAD_EN
            ret_state <= IDLE;
`endif
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ep_read) begin
                if (rd) begin
                    ep_datain <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + 1'b1;
                end else begin
                    ep_datain <= 32'hDEAD_BEEF;
                    underflow <= 1'b1;
                end
            end
            if (ferr_set) begin
                frame_err <= 1'b1;
            end
            level    <= level_next;
            in_ready <= in_ready_nx;
            ep_ready <= level_next >= BW_L;
            state    <= state_nx;
            cnt      <= cnt_nx;
`ifdef BT_PIPE_OUT_BUF_PAD_EN
            ret_state <= frame_nx;
`endif
        end
    end

endmodule

// File: tb/tb_bt_pipe_out_buffer.sv
// Testbench for bt_pipe_out_buffer (ADDR_W=4, BLOCK_WORDS=4).
// Table vectors, hand sequences and a queue-based reference model.
module tb_bt_pipe_out_buffer;

    localparam int AW = 4;
    localparam int BW = 4;
    localparam int DEPTH = 16;

    logic          okClk = 1'b0;
    logic          rst_n;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   ep_datain;
    logic          ep_ready;
    logic          ep_read;
    logic          ep_blockstrobe;
    logic [AW:0]   level;
    logic          underflow;
    logic          frame_err;
    logic          flush;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] q[$];
    bit          m_inrdy;
    bit          m_uf;
    bit          m_fe;
    bit          m_blk;
    int          m_cnt;
    logic [31:0] m_dout;

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          r;
        bit          s;
        int          lvl;
        bit          rdy;
        logic [31:0] dout;
        bit          fe;
    } vec_t;

    vec_t tbl[10];

    bt_pipe_out_buffer #(
        .ADDR_W(AW),
        .BLOCK_WORDS(BW),
        .PAD_WORD(32'h0)
    ) dut (
        .okClk(okClk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
`ifdef BT_PIPE_OUT_BUF_PAD_EN
        .flush(flush),
`endif
        .ep_datain(ep_datain),
        .ep_ready(ep_ready),
        .ep_read(ep_read),
        .ep_blockstrobe(ep_blockstrobe),
        .level(level),
        .underflow(underflow),
        .frame_err(frame_err)
    );

    always #5 okClk = ~okClk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_inrdy = 1'b0;
        m_uf    = 1'b0;
        m_fe    = 1'b0;
        m_blk   = 1'b0;
        m_cnt   = 0;
        m_dout  = 32'h0;
    endtask

    // one clock with the given inputs; model advanced and compared
    task automatic step(input bit v, input logic [31:0] d,
                        input bit r, input bit s);
        bit had;
        in_valid       = v;
        in_data        = d;
        ep_read        = r;
        ep_blockstrobe = s;
        @(posedge okClk);
        #1;
        in_valid       = 1'b0;
        ep_read        = 1'b0;
        ep_blockstrobe = 1'b0;
        had = q.size() > 0;
        if (r) begin
            if (had) begin
                m_dout = q.pop_front();
            end else begin
                m_dout = 32'hDEAD_BEEF;
                m_uf   = 1'b1;
            end
        end
        if (v && m_inrdy) q.push_back(d);
        if (m_blk) begin
            if (s) begin
                m_fe  = 1'b1;
                m_cnt = 0;
            end else if (r) begin
                m_cnt++;
                if (m_cnt == BW) begin
                    m_blk = 1'b0;
                    m_cnt = 0;
                end
            end
        end else begin
            if (s) begin
                m_blk = 1'b1;
                m_cnt = 0;
            end else if (r) begin
                m_fe = 1'b1;
            end
        end
        m_inrdy = q.size() < DEPTH;
        chk("m_level", level, q.size());
        chk("m_in_ready", in_ready, m_inrdy);
        chk("m_ep_ready", ep_ready, q.size() >= BW);
        chk("m_ep_datain", ep_datain, m_dout);
        chk("m_underflow", underflow, m_uf);
        chk("m_frame_err", frame_err, m_fe);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge okClk);
        #1;
        model_reset();
        chk("rst_level", level, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ep_ready", ep_ready, 0);
        chk("rst_ep_datain", ep_datain, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_frame_err", frame_err, 0);
        rst_n = 1'b1;
        step(0, 0, 0, 0);
        chk("post_rst_in_ready", in_ready, 1);
    endtask

    initial begin
        rst_n          = 1'b0;
        in_data        = '0;
        in_valid       = 1'b0;
        ep_read        = 1'b0;
        ep_blockstrobe = 1'b0;
        flush          = 1'b0;

        tbl[0] = '{1, 32'h1, 0, 0, 1, 0, 32'h0, 0};
        tbl[1] = '{1, 32'h2, 0, 0, 2, 0, 32'h0, 0};
        tbl[2] = '{1, 32'h3, 0, 0, 3, 0, 32'h0, 0};
        tbl[3] = '{1, 32'h4, 0, 0, 4, 1, 32'h0, 0};
        tbl[4] = '{0, 32'h0, 0, 1, 4, 1, 32'h0, 0};
        tbl[5] = '{0, 32'h0, 1, 0, 3, 0, 32'h1, 0};
        tbl[6] = '{0, 32'h0, 1, 0, 2, 0, 32'h2, 0};
        tbl[7] = '{0, 32'h0, 1, 0, 1, 0, 32'h3, 0};
        tbl[8] = '{0, 32'h0, 1, 0, 0, 0, 32'h4, 0};
        tbl[9] = '{0, 32'h0, 0, 0, 0, 0, 32'h4, 0};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].s);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("tbl%0d_ep_ready", i), ep_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_ep_datain", i), ep_datain, tbl[i].dout);
            chk($sformatf("tbl%0d_frame_err", i), frame_err, tbl[i].fe);
        end

        // fill to full, then read/write at and near full
        for (int i = 0; i < DEPTH; i++) step(1, $urandom, 0, 0);
        chk("full_level", level, 16);
        chk("full_in_ready", in_ready, 0);
        step(0, 0, 0, 1);
        step(1, 32'hBAD0_0001, 1, 0);
        chk("full_rd_wr_level", level, 15);
        step(1, 32'h5A5A_0001, 1, 0);
        chk("near_full_rd_wr_level", level, 15);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int b = 0; b < 3; b++) begin
            step(0, 0, 0, 1);
            for (int k = 0; k < BW; k++) step(0, 0, 1, 0);
        end
        chk("drain_level", level, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        chk("drain_last_word", ep_datain, 32'h5A5A_0001);

        // read while empty inside a block
        step(0, 0, 1, 0);
        chk("uf_datain", ep_datain, 32'hDEAD_BEEF);
        chk("uf_flag", underflow, 1);
        chk("uf_no_frame_err", frame_err, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("uf_sticky", underflow, 1);

        // strobe mid-block
        for (int i = 0; i < BW; i++) step(1, 32'hC0 + i, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("fe_before", frame_err, 0);
        step(0, 0, 0, 1);
        chk("fe_mid_strobe", frame_err, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit r;
            bit s;
            if (i < 200) begin
                v = $urandom_range(99) < 80;
                r = $urandom_range(99) < 30;
            end else begin
                v = $urandom_range(99) < 30;
                r = $urandom_range(99) < 80;
            end
            s = $urandom_range(99) < 8;
            step(v, $urandom, r, s);
        end

        // reset clears flags and discards contents
        do_reset();
        chk("rst2_underflow", underflow, 0);
        chk("rst2_level", level, 0);

`ifdef BT_PIPE_OUT_BUF_PAD_EN
        step(1, 32'hA, 0, 0);
        step(1, 32'hB, 0, 0);
        flush = 1'b1;
        @(posedge okClk);
        #1;
        flush = 1'b0;
        chk("pad_in_ready0", in_ready, 0);
        @(posedge okClk);
        #1;
        chk("pad_in_ready1", in_ready, 0);
        chk("pad_level3", level, 3);
        @(posedge okClk);
        #1;
        chk("pad_level4", level, 4);
        chk("pad_ep_ready", ep_ready, 1);
        @(posedge okClk);
        #1;
        chk("pad_exit_in_ready", in_ready, 1);
        chk("pad_level_hold", level, 4);
        q.delete();
        q.push_back(32'hA);
        q.push_back(32'hB);
        q.push_back(32'h0);
        q.push_back(32'h0);
        m_inrdy = 1'b1;
        step(0, 0, 0, 1);
        for (int k = 0; k < BW; k++) step(0, 0, 1, 0);
        chk("pad_last_word", ep_datain, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
